// File: rtl/uart_pkg.sv
// uart_pkg -- shared types and constants for the UART receive word packer.
//
// Contents:
//   byte_t / word_t      : 8-bit received byte and 32-bit packed word
//   asm_state_t          : assembler state B0..B3 (value = bytes already held)
//   FIFO_DEPTH_DEFAULT   : default word FIFO depth
//   place_byte()         : writes a byte into the lane selected by a byte index
//
// Build option: UART_RX_PACK_BIG_ENDIAN_EN
//   If defined, byte index 0 maps to bits [31:24].
//   Otherwise byte index 0 maps to bits [7:0] (little-endian, the default).
package uart_pkg;

   typedef logic [7:0]  byte_t;
   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      B0 = 2'd0,
      B1 = 2'd1,
      B2 = 2'd2,
      B3 = 2'd3
   } asm_state_t;

   localparam int FIFO_DEPTH_DEFAULT = 4;

   function automatic word_t place_byte(input word_t w, input byte_t b, input logic [1:0] idx);
      word_t r;
      r = w;
`ifdef UART_RX_PACK_BIG_ENDIAN_EN
      r[{~idx, 3'b000} +: 8] = b;
`else
      r[{idx, 3'b000} +: 8] = b;
`endif
      return r;
   endfunction

endpackage

// File: rtl/uart_word_fifo.sv
// uart_word_fifo -- synchronous word FIFO for the UART receive packer.
//
// Ports:
//   clk, rstn        : clock and asynchronous active-low reset
//   push, push_data  : write request and data; accepted if not full, or if
//                      full and a pop happens on the same edge
//   pop              : read request; ignored when empty
//   head_data        : entry at the read pointer
//   full, empty      : derived from the occupancy counter
//
// Pointers wrap naturally because DEPTH is a power of two. The occupancy
// counter is one bit wider than the pointers so full and empty differ.
module uart_word_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   assign full      = (count == CW'(DEPTH));
   assign empty     = (count == '0);
   assign do_pop    = pop && !empty;
   assign do_push   = push && (!full || do_pop);
   assign head_data = mem[rd_ptr];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_packer.sv
// uart_rx_packer -- packs received UART bytes into 32-bit words and queues
// them in a small FIFO for a valid/ready consumer.
//
// Ports:
//   clk, rstn              : clock and asynchronous active-low reset
//   byte_valid, byte_data  : one-cycle strobe plus received byte
//   flush                  : drop the partial word (and any same-cycle byte)
//   word_valid, word_data  : FIFO head; word_valid is registered state only
//   word_ready             : consumer accepts the head word
//   byte_count             : bytes held in the partial word (0-3)
//   overflow               : sticky; a completed word was dropped on a full FIFO
//
// Build option: UART_RX_PACK_BIG_ENDIAN_EN selects big-endian byte placement;
// little-endian when undefined.
//
// Assembler states:
//   state | meaning
//   B0    | no bytes held; next byte goes to lane 0
//   B1    | one byte held; next byte goes to lane 1
//   B2    | two bytes held; next byte goes to lane 2
//   B3    | three bytes held; next byte completes and pushes the word
module uart_rx_packer
   import uart_pkg::*;
#(
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   input  logic        flush,
   output logic        word_valid,
   output logic [31:0] word_data,
   input  logic        word_ready,
   output logic [1:0]  byte_count,
   output logic        overflow
);

   asm_state_t state;
   asm_state_t state_nxt;
   word_t      partial;
   word_t      partial_nxt;
   word_t      assembled;
   logic       push;
   logic       pop;
   logic       full;
   logic       empty;
   logic       overflow_nxt;

   assign word_valid = !empty;
   assign pop        = word_valid && word_ready;
   assign byte_count = state;
   assign assembled  = place_byte(partial, byte_data, state);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= B0;
         partial  <= '0;
         overflow <= 1'b0;
      end else begin
         state    <= state_nxt;
         partial  <= partial_nxt;
         overflow <= overflow_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      partial_nxt  = partial;
      push         = 1'b0;
      overflow_nxt = overflow;
      if (flush) begin
         state_nxt   = B0;
         partial_nxt = '0;
      end else if (byte_valid) begin
         case (state)
            B0: begin
               state_nxt   = B1;
               partial_nxt = assembled;
            end
            B1: begin
               state_nxt   = B2;
               partial_nxt = assembled;
            end
            B2: begin
               state_nxt   = B3;
               partial_nxt = assembled;
            end
            default: begin
               state_nxt   = B0;
               partial_nxt = '0;
               push        = 1'b1;
            end
         endcase
      end
      // A full FIFO still accepts the word if the head leaves on this edge.
      if (push && full && !pop) begin
         overflow_nxt = 1'b1;
      end
   end

   uart_word_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (32)
   ) u_fifo (
      .clk       (clk),
      .rstn      (rstn),
      .push      (push),
      .push_data (assembled),
      .pop       (pop),
      .head_data (word_data),
      .full      (full),
      .empty     (empty)
   );

endmodule

// File: tb/tb_uart_rx_packer.sv
module tb_uart_rx_packer;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        byte_valid = 1'b0;
   logic [7:0]  byte_data = 8'h00;
   logic        flush = 1'b0;
   logic        word_valid;
   logic [31:0] word_data;
   logic        word_ready = 1'b0;
   logic [1:0]  byte_count;
   logic        overflow;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0]  m_part[$];
   logic [31:0] m_fifo[$];
   logic        m_ovf = 1'b0;

   always #5 clk = ~clk;

   uart_rx_packer #(.FIFO_DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .flush      (flush),
      .word_valid (word_valid),
      .word_data  (word_data),
      .word_ready (word_ready),
      .byte_count (byte_count),
      .overflow   (overflow)
   );

   function automatic logic [31:0] form_word(input logic [7:0] b0, input logic [7:0] b1,
                                             input logic [7:0] b2, input logic [7:0] b3);
`ifdef UART_RX_PACK_BIG_ENDIAN_EN
      return {b0, b1, b2, b3};
`else
      return {b3, b2, b1, b0};
`endif
   endfunction

   // One clock: apply inputs, advance the reference model at the edge,
   // return at the following falling edge where outputs are sampled.
   task automatic cycle(input logic bv, input logic [7:0] bd, input logic fl, input logic rdy);
      logic [31:0] w;
      byte_valid = bv;
      byte_data  = bd;
      flush      = fl;
      word_ready = rdy;
      @(posedge clk);
      if (m_fifo.size() > 0 && rdy) void'(m_fifo.pop_front());
      if (fl) begin
         m_part.delete();
      end else if (bv) begin
         m_part.push_back(bd);
         if (m_part.size() == 4) begin
            w = form_word(m_part[0], m_part[1], m_part[2], m_part[3]);
            if (m_fifo.size() < DEPTH) m_fifo.push_back(w);
            else m_ovf = 1'b1;
            m_part.delete();
         end
      end
      @(negedge clk);
      byte_valid = 1'b0;
      flush      = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rstn = 1'b0;
      byte_valid = 1'b0;
      flush = 1'b0;
      word_ready = 1'b0;
      m_part.delete();
      m_fifo.delete();
      m_ovf = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      #12;
      n_checks++; if (word_valid !== 1'b0) begin n_fail++; $display("FAIL reset_word_valid got=%b exp=0", word_valid); end
      n_checks++; if (word_data !== 32'h0) begin n_fail++; $display("FAIL reset_word_data got=%h exp=0", word_data); end
      n_checks++; if (byte_count !== 2'd0) begin n_fail++; $display("FAIL reset_byte_count got=%0d exp=0", byte_count); end
      n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
      @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic test_basic();
      logic [31:0] exp;
`ifdef UART_RX_PACK_BIG_ENDIAN_EN
      exp = 32'h11223344;
`else
      exp = 32'h44332211;
`endif
      do_reset();
      cycle(1, 8'h11, 0, 1);
      cycle(1, 8'h22, 0, 1);
      cycle(1, 8'h33, 0, 1);
      n_checks++; if (byte_count !== 2'd3) begin n_fail++; $display("FAIL basic_count3 got=%0d exp=3", byte_count); end
      n_checks++; if (word_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid got=%b exp=0", word_valid); end
      cycle(1, 8'h44, 0, 1);
      n_checks++; if (word_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got=%b exp=1", word_valid); end
      n_checks++; if (word_data !== exp) begin n_fail++; $display("FAIL basic_data got=%h exp=%h", word_data, exp); end
      n_checks++; if (byte_count !== 2'd0) begin n_fail++; $display("FAIL basic_count0 got=%0d exp=0", byte_count); end
      cycle(0, 8'h00, 0, 1);
      n_checks++; if (word_valid !== 1'b0) begin n_fail++; $display("FAIL basic_one_cycle got=%b exp=0", word_valid); end
   endtask

   task automatic test_overflow();
      logic [7:0]  b[20];
      logic [31:0] exp[4];
      int n;
      do_reset();
      for (int i = 0; i < 20; i++) begin
         b[i] = 8'($urandom);
         cycle(1, b[i], 0, 0);
      end
      for (int k = 0; k < 4; k++) exp[k] = form_word(b[4*k], b[4*k+1], b[4*k+2], b[4*k+3]);
      n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
      n_checks++; if (byte_count !== 2'd0) begin n_fail++; $display("FAIL ovf_count got=%0d exp=0", byte_count); end
      n = 0;
      repeat (8) begin
         if (word_valid === 1'b1) begin
            if (n < 4) begin
               n_checks++; if (word_data !== exp[n]) begin n_fail++; $display("FAIL ovf_drain_data[%0d] got=%h exp=%h", n, word_data, exp[n]); end
            end
            n++;
         end
         cycle(0, 8'h00, 0, 1);
      end
      n_checks++; if (n !== 4) begin n_fail++; $display("FAIL ovf_drain_count got=%0d exp=4", n); end
      n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
   endtask

   task automatic test_full_concurrent();
      logic [7:0]  b[20];
      logic [31:0] exp[4];
      int n;
      do_reset();
      for (int i = 0; i < 19; i++) begin
         b[i] = 8'($urandom);
         cycle(1, b[i], 0, 0);
      end
      b[19] = 8'($urandom);
      cycle(1, b[19], 0, 1);
      for (int k = 0; k < 4; k++) exp[k] = form_word(b[4*k+4], b[4*k+5], b[4*k+6], b[4*k+7]);
      n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL full_pop_ovf got=%b exp=0", overflow); end
      n = 0;
      repeat (8) begin
         if (word_valid === 1'b1) begin
            if (n < 4) begin
               n_checks++; if (word_data !== exp[n]) begin n_fail++; $display("FAIL full_pop_data[%0d] got=%h exp=%h", n, word_data, exp[n]); end
            end
            n++;
         end
         cycle(0, 8'h00, 0, 1);
      end
      n_checks++; if (n !== 4) begin n_fail++; $display("FAIL full_pop_occupancy got=%0d exp=4", n); end
   endtask

   task automatic test_flush();
      logic [31:0] exp;
      exp = form_word(8'h01, 8'h02, 8'h03, 8'h04);
      do_reset();
      cycle(1, 8'hAA, 0, 0);
      cycle(1, 8'hBB, 0, 0);
      cycle(0, 8'h00, 1, 0);
      n_checks++; if (byte_count !== 2'd0) begin n_fail++; $display("FAIL flush_count got=%0d exp=0", byte_count); end
      cycle(1, 8'h01, 0, 0);
      cycle(1, 8'h02, 0, 0);
      cycle(1, 8'h03, 0, 0);
      cycle(1, 8'h04, 0, 0);
      n_checks++; if (word_data !== exp || word_valid !== 1'b1) begin n_fail++; $display("FAIL flush_word got=%h/%b exp=%h/1", word_data, word_valid, exp); end
      cycle(0, 8'h00, 0, 1);
      n_checks++; if (word_valid !== 1'b0) begin n_fail++; $display("FAIL flush_single got=%b exp=0", word_valid); end
      // a byte arriving together with flush is discarded
      cycle(1, 8'h55, 0, 0);
      cycle(1, 8'h66, 1, 0);
      n_checks++; if (byte_count !== 2'd0) begin n_fail++; $display("FAIL flush_same_cycle got=%0d exp=0", byte_count); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] exp;
      do_reset();
      for (int i = 0; i < 10; i++) cycle(1, 8'($urandom), 0, 0);
      rstn = 1'b0;
      #2;
      n_checks++; if (word_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got=%b exp=0", word_valid); end
      n_checks++; if (byte_count !== 2'd0) begin n_fail++; $display("FAIL rstmid_count got=%0d exp=0", byte_count); end
      n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rstmid_ovf got=%b exp=0", overflow); end
      m_part.delete();
      m_fifo.delete();
      m_ovf = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      cycle(1, 8'hDE, 0, 0);
      cycle(1, 8'hAD, 0, 0);
      cycle(1, 8'hBE, 0, 0);
      cycle(1, 8'hEF, 0, 0);
      exp = form_word(8'hDE, 8'hAD, 8'hBE, 8'hEF);
      n_checks++; if (word_valid !== 1'b1 || word_data !== exp) begin n_fail++; $display("FAIL rstmid_word got=%h/%b exp=%h/1", word_data, word_valid, exp); end
   endtask

   task automatic test_random();
      int errs;
      errs = 0;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         cycle(($urandom_range(0, 99) < 60), 8'($urandom), ($urandom_range(0, 99) < 4),
               ($urandom_range(0, 99) < 35));
         n_checks++;
         if (word_valid !== (m_fifo.size() != 0) || byte_count !== 2'(m_part.size()) ||
             overflow !== m_ovf || (m_fifo.size() != 0 && word_data !== m_fifo[0])) begin
            n_fail++;
            if (errs < 10)
               $display("FAIL random[%0d] got v=%b d=%h c=%0d o=%b exp v=%b d=%h c=%0d o=%b", i,
                        word_valid, word_data, byte_count, overflow, (m_fifo.size() != 0),
                        (m_fifo.size() != 0) ? m_fifo[0] : 32'h0, m_part.size(), m_ovf);
            errs++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_flush();
      test_full_concurrent();
      test_overflow();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
